// File: rtl/pc_seq_if.sv
// pc_seq_if: control/fetch bundle between the control unit, branch comparator,
// instruction memory and the program-counter sequencer.
//   master : control side (drives stall/branch/jump/halt/resume, observes PC)
//   slave  : pc_sequencer side (observes requests, drives pc_out/pc_plus4,
//            fetch_valid, seq_state, trap)
interface pc_seq_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic             jump;
  logic [WIDTH-1:0] jump_target;
  logic             halt;
  logic             resume;
  logic [WIDTH-1:0] pc_out;
  logic [WIDTH-1:0] pc_plus4;
  logic             fetch_valid;
  logic [1:0]       seq_state;
  logic             trap;

  modport master (
    output stall, branch_taken, branch_target, jump, jump_target, halt, resume,
    input  pc_out, pc_plus4, fetch_valid, seq_state, trap
  );

  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_target, halt, resume,
    output pc_out, pc_plus4, fetch_valid, seq_state, trap
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the program counter and picks the next fetch address:
// sequential +4, jump/branch redirect (followed by FLUSH_CYCLES bubbles),
// stall hold, halt/resume.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    pc_seq_if.slave (requests in; pc_out, pc_plus4, fetch_valid,
//          seq_state, trap out)
// Build option: define PC_SEQ_ALIGN_TRAP_EN to trap on a misaligned redirect
// target (pc <= TRAP_VECTOR, one TRAP cycle). Without it the low two target
// bits are cleared and trap is tied low.
//
// state | meaning
// RUN   | fetching; pc advances by 4 unless held or redirected
// FLUSH | bubbles after a redirect; pc held, requests ignored
// HALT  | fetch stopped until resume
// TRAP  | one-cycle misaligned-target trap (alignment-trap build only)
module pc_sequencer #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               FLUSH_CYCLES = 1,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h0000_0100)
) (
  input logic     clk,
  input logic     reset,
  pc_seq_if.slave bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2,
    TRAP  = 2'd3
  } state_e;

  localparam logic [2:0]       FLUSH_INIT = 3'(FLUSH_CYCLES);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] redirect_tgt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      pc_q    <= RESET_VECTOR;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // jump wins over a simultaneous taken branch
  assign redirect_tgt = bus.jump ? bus.jump_target : bus.branch_target;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (bus.halt) begin
          state_d = HALT;
        end else if (bus.jump || bus.branch_taken) begin
          pc_d = redirect_tgt & ALIGN_MASK;
          if (FLUSH_INIT == 3'd0) begin
            state_d = RUN;
          end else begin
            state_d = FLUSH;
            cnt_d   = FLUSH_INIT;
          end
`ifdef PC_SEQ_ALIGN_TRAP_EN
          if (redirect_tgt[1:0] != 2'b00) begin
            pc_d    = TRAP_VECTOR;
            state_d = TRAP;
            cnt_d   = 3'd0;
          end
`endif
        end else if (!bus.stall) begin
          pc_d = pc_q + WIDTH'(4);
        end
      end
      FLUSH: begin
        if (cnt_q <= 3'd1) begin
          state_d = RUN;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      HALT: begin
        if (bus.resume) state_d = RUN;
      end
      TRAP: begin
        // pc already holds TRAP_VECTOR; restating it keeps the hold explicit
        pc_d    = TRAP_VECTOR;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign bus.pc_out      = pc_q;
  assign bus.pc_plus4    = pc_q + WIDTH'(4);
  assign bus.fetch_valid = (state_q == RUN) && !bus.stall;
  assign bus.seq_state   = state_q;
`ifdef PC_SEQ_ALIGN_TRAP_EN
  assign bus.trap        = (state_q == TRAP);
`else
  assign bus.trap        = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  logic clk;
  logic reset;
  int   checks;
  int   passes;
  logic [31:0] exp_q[$];

  pc_seq_if #(.WIDTH(32)) bus ();

  pc_sequencer #(
    .WIDTH(32),
    .RESET_VECTOR(32'h0000_0000),
    .FLUSH_CYCLES(1),
    .TRAP_VECTOR(32'h0000_0100)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.jump = 1'b0;
    bus.halt = 1'b0; bus.resume = 1'b0;
  endtask

  // Monitor: every real fetch must match the next expected fetch address.
  always @(negedge clk) begin
    if (reset && bus.fetch_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL fetch_unexpected actual=%h required=none", bus.pc_out);
      end else begin
        check("fetch_pc", bus.pc_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    passes = 0;
    reset = 1'b0;
    clear_req();
    bus.branch_target = '0;
    bus.jump_target   = '0;

    // 1: reset values, then sequential fetch
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", bus.pc_out, 32'h0);
    check("rst_state", 32'(bus.seq_state), 32'd0);
    check("rst_trap", 32'(bus.trap), 32'd0);
    exp_q.push_back(32'h0);  exp_q.push_back(32'h4);  exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);  exp_q.push_back(32'h10);
    reset = 1'b1;
    check("rel_fetch_valid", 32'(bus.fetch_valid), 32'd1);
    check("pc_plus4_at_0", bus.pc_plus4, 32'h4);
    repeat (4) tick();

    // 2: taken branch at 0x10 -> one bubble, then 0x40, 0x44
    exp_q.push_back(32'h40); exp_q.push_back(32'h44);
    bus.branch_taken = 1'b1; bus.branch_target = 32'h40;
    tick();
    clear_req();
    check("br_pc", bus.pc_out, 32'h40);
    check("br_state_flush", 32'(bus.seq_state), 32'd1);
    check("br_fetch_valid", 32'(bus.fetch_valid), 32'd0);
    tick();
    tick();

    // 3: jump beats branch, then stall holds 3 clocks
    exp_q.push_back(32'h80); exp_q.push_back(32'h84);
    bus.jump = 1'b1; bus.jump_target = 32'h80;
    bus.branch_taken = 1'b1; bus.branch_target = 32'h40;
    tick();
    clear_req();
    check("jmp_pc", bus.pc_out, 32'h80);
    tick();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", bus.pc_out, 32'h80);
      check("stall_fetch_valid", 32'(bus.fetch_valid), 32'd0);
    end
    bus.stall = 1'b0;
    tick();

    // 4: halt (beats a simultaneous jump), hold 5 clocks, resume beats halt
    exp_q.push_back(32'h20); exp_q.push_back(32'h20); exp_q.push_back(32'h24);
    bus.jump = 1'b1; bus.jump_target = 32'h20;
    tick();
    clear_req();
    tick();
    bus.halt = 1'b1; bus.jump = 1'b1; bus.jump_target = 32'h300;
    tick();
    clear_req();
    check("halt_state", 32'(bus.seq_state), 32'd2);
    check("halt_pc", bus.pc_out, 32'h20);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("halt_hold_pc", bus.pc_out, 32'h20);
      check("halt_fetch_valid", 32'(bus.fetch_valid), 32'd0);
    end
    bus.resume = 1'b1; bus.halt = 1'b1;
    tick();
    clear_req();
    check("resume_state", 32'(bus.seq_state), 32'd0);
    check("resume_pc", bus.pc_out, 32'h20);
    tick();

    // 5: wrap at the top of the address space
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
    bus.jump = 1'b1; bus.jump_target = 32'hFFFF_FFFC;
    tick();
    clear_req();
    tick();
    check("wrap_pc_plus4", bus.pc_plus4, 32'h0);
    tick();

    // 6: misaligned jump target 0x42
    bus.jump = 1'b1; bus.jump_target = 32'h42;
    tick();
    clear_req();
`ifdef PC_SEQ_ALIGN_TRAP_EN
    exp_q.push_back(32'h100);
    check("mis_state_trap", 32'(bus.seq_state), 32'd3);
    check("mis_trap", 32'(bus.trap), 32'd1);
    check("mis_pc", bus.pc_out, 32'h100);
    check("mis_fetch_valid", 32'(bus.fetch_valid), 32'd0);
`else
    exp_q.push_back(32'h40);
    check("mis_state_flush", 32'(bus.seq_state), 32'd1);
    check("mis_trap", 32'(bus.trap), 32'd0);
    check("mis_pc", bus.pc_out, 32'h40);
`endif
    tick();
    check("post_mis_trap", 32'(bus.trap), 32'd0);

    // reset pulsed mid-FLUSH
    bus.branch_taken = 1'b1; bus.branch_target = 32'h60;
    tick();
    clear_req();
    check("pre_rst_state", 32'(bus.seq_state), 32'd1);
    check("pre_rst_pc", bus.pc_out, 32'h60);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    reset = 1'b0;
    #1;
    check("mid_rst_pc", bus.pc_out, 32'h0);
    check("mid_rst_state", 32'(bus.seq_state), 32'd0);
    check("mid_rst_trap", 32'(bus.trap), 32'd0);
    reset = 1'b1;
    tick();
    @(negedge clk);
    #1;
    bus.stall = 1'b1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
